reg_select_load: RTL and testbench

REG_SELECT_LOAD -- requirements
Module: reg_select_load

---
 rtl/reg_select_load.sv | 77 +++++++
 tb/tb_reg_select_load.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_select_load.sv
// 16x32 general-purpose register file with IR field select, HI/LO registers and write statistics.
// Optional BA_ZERO_EN: a base-address read of register 0 returns zero instead of R0's contents.
module reg_select_load (
  input  logic        clock,
  input  logic        clear_n,
  input  logic [31:0] bus_in,
  input  logic [31:0] ir,
  input  logic        Gra,
  input  logic        Grb,
  input  logic        Grc,
  input  logic        Rin,
  input  logic        Rout,
  input  logic        BAout,
  input  logic        HIin,
  input  logic        LOin,
  output logic [31:0] rdata,
  output logic [15:0] rout_onehot,
  output logic [31:0] hi_q,
  output logic [31:0] lo_q,
  output logic [31:0] csign,
  output logic        multi_sel_err,
  output logic [7:0]  wr_count
);

  logic [31:0] regs [16];
  logic [3:0]  field;
  logic        multi_sel;
  logic        unused_ir_bits;

  assign field = (ir[26:23] & {4{Gra}})
               | (ir[22:19] & {4{Grb}})
               | (ir[18:15] & {4{Grc}});

  // Only an active access with two or more selects counts as an error.
  assign multi_sel = ((Gra & Grb) | (Gra & Grc) | (Grb & Grc)) & (Rin | Rout | BAout);

  assign csign          = {{13{ir[18]}}, ir[18:0]};
  assign unused_ir_bits = ^ir[31:27];

  always_comb begin
    rout_onehot = 16'h0000;
    if (Rout || BAout)
      rout_onehot = 16'h0001 << field;
  end

  always_comb begin
    rdata = regs[field];
`ifdef BA_ZERO_EN
    if (BAout && (field == 4'd0))
      rdata = 32'h0000_0000;
`endif
  end

  always_ff @(posedge clock) begin
    if (!clear_n) begin
      for (int i = 0; i < 16; i++)
        regs[i] <= 32'h0000_0000;
      hi_q          <= 32'h0000_0000;
      lo_q          <= 32'h0000_0000;
      wr_count      <= 8'h00;
      multi_sel_err <= 1'b0;
    end else begin
      if (Rin) begin
        regs[field] <= bus_in;
        if (wr_count != 8'hFF)
          wr_count <= wr_count + 8'd1;
      end
      if (HIin)
        hi_q <= bus_in;
      if (LOin)
        lo_q <= bus_in;
      if (multi_sel)
        multi_sel_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_select_load.sv
// Directed self-checking bench for reg_select_load; honours BA_ZERO_EN when defined.
module tb_reg_select_load;

  logic        clock = 1'b0;
  logic        clear_n;
  logic [31:0] bus_in;
  logic [31:0] ir;
  logic        Gra, Grb, Grc, Rin, Rout, BAout, HIin, LOin;
  logic [31:0] rdata;
  logic [15:0] rout_onehot;
  logic [31:0] hi_q, lo_q, csign;
  logic        multi_sel_err;
  logic [7:0]  wr_count;

  int errors = 0;
  int checks = 0;

  reg_select_load dut (
    .clock(clock), .clear_n(clear_n), .bus_in(bus_in), .ir(ir),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .HIin(HIin), .LOin(LOin), .rdata(rdata), .rout_onehot(rout_onehot),
    .hi_q(hi_q), .lo_q(lo_q), .csign(csign), .multi_sel_err(multi_sel_err),
    .wr_count(wr_count)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mk_ir(input logic [3:0] ra, input logic [3:0] rb,
                                        input logic [3:0] rc);
    return {5'b0, ra, rb, rc, 15'b0};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    {Gra, Grb, Grc, Rin, Rout, BAout, HIin, LOin} = '0;
  endtask

  task automatic test_reset();
    idle();
    clear_n = 1'b0;
    Rin = 1'b1; HIin = 1'b1; LOin = 1'b1; Gra = 1'b1;
    ir = mk_ir(4'd6, 4'd0, 4'd0);
    bus_in = 32'hFFFF_FFFF;
    tick();
    idle();
    if (hi_q !== 32'h0) begin errors++; $display("[TB] FAIL reset_hi: got %h want 0", hi_q); end
    checks++;
    if (lo_q !== 32'h0) begin errors++; $display("[TB] FAIL reset_lo: got %h want 0", lo_q); end
    checks++;
    if (wr_count !== 8'h0) begin errors++; $display("[TB] FAIL reset_wr_count: got %h want 0", wr_count); end
    checks++;
    if (multi_sel_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b want 0", multi_sel_err); end
    checks++;
    clear_n = 1'b1;
    Rout = 1'b1; Gra = 1'b1;
    for (int r = 0; r < 16; r++) begin
      ir = mk_ir(r[3:0], 4'd0, 4'd0);
      #1;
      if (rdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_R%0d: got %h want 0", r, rdata); end
      checks++;
    end
    idle();
  endtask

  task automatic test_load_read();
    idle();
    ir = mk_ir(4'd5, 4'd0, 4'd0);
    Gra = 1'b1; Rin = 1'b1; bus_in = 32'hDEAD_BEEF;
    tick();
    Rin = 1'b0; Rout = 1'b1;
    #1;
    if (rdata !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL load_R5: got %h want deadbeef", rdata); end
    checks++;
    if (rout_onehot !== 16'h0020) begin errors++; $display("[TB] FAIL onehot_R5: got %h want 0020", rout_onehot); end
    checks++;
    if (wr_count !== 8'd1) begin errors++; $display("[TB] FAIL wr_count_1: got %0d want 1", wr_count); end
    checks++;
    idle();
  endtask

  task automatic test_read_during_write();
    idle();
    ir = mk_ir(4'd5, 4'd0, 4'd0);
    Gra = 1'b1; Rin = 1'b1; Rout = 1'b1; bus_in = 32'hCAFE_F00D;
    #1;
    if (rdata !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL rdw_old: got %h want deadbeef", rdata); end
    checks++;
    tick();
    Rin = 1'b0;
    #1;
    if (rdata !== 32'hCAFE_F00D) begin errors++; $display("[TB] FAIL rdw_new: got %h want cafef00d", rdata); end
    checks++;
    idle();
  endtask

  task automatic test_field_select();
    idle();
    ir = mk_ir(4'd0, 4'd9, 4'd0);
    Grb = 1'b1; Rin = 1'b1; bus_in = 32'h0000_0099;
    tick();
    idle();
    ir = mk_ir(4'd0, 4'd0, 4'd9);
    Grc = 1'b1; Rout = 1'b1;
    #1;
    if (rdata !== 32'h99) begin errors++; $display("[TB] FAIL grc_R9: got %h want 99", rdata); end
    checks++;
    if (rout_onehot !== 16'h0200) begin errors++; $display("[TB] FAIL onehot_R9: got %h want 0200", rout_onehot); end
    checks++;
    Grc = 1'b0;
    #1;
    if (rout_onehot !== 16'h0001) begin errors++; $display("[TB] FAIL onehot_nosel: got %h want 0001", rout_onehot); end
    checks++;
    Rout = 1'b0;
    #1;
    if (rout_onehot !== 16'h0000) begin errors++; $display("[TB] FAIL onehot_idle: got %h want 0000", rout_onehot); end
    checks++;
    if (wr_count !== 8'd3) begin errors++; $display("[TB] FAIL wr_count_3: got %0d want 3", wr_count); end
    checks++;
  endtask

  task automatic test_ba_read();
    idle();
    ir = mk_ir(4'd0, 4'd0, 4'd0);
    Gra = 1'b1; Rin = 1'b1; bus_in = 32'h0000_1234;
    tick();
    Rin = 1'b0; BAout = 1'b1;
    #1;
`ifdef BA_ZERO_EN
    if (rdata !== 32'h0) begin errors++; $display("[TB] FAIL ba_R0: got %h want 0", rdata); end
`else
    if (rdata !== 32'h1234) begin errors++; $display("[TB] FAIL ba_R0: got %h want 1234", rdata); end
`endif
    checks++;
    if (rout_onehot !== 16'h0001) begin errors++; $display("[TB] FAIL ba_onehot: got %h want 0001", rout_onehot); end
    checks++;
    BAout = 1'b0; Rout = 1'b1;
    #1;
    if (rdata !== 32'h1234) begin errors++; $display("[TB] FAIL rout_R0: got %h want 1234", rdata); end
    checks++;
    Rout = 1'b0; BAout = 1'b1;
    ir = mk_ir(4'd5, 4'd0, 4'd0);
    #1;
    if (rdata !== 32'hCAFE_F00D) begin errors++; $display("[TB] FAIL ba_R5: got %h want cafef00d", rdata); end
    checks++;
    idle();
  endtask

  task automatic test_multi_sel();
    idle();
    if (multi_sel_err !== 1'b0) begin errors++; $display("[TB] FAIL err_before: got %b want 0", multi_sel_err); end
    checks++;
    ir = mk_ir(4'd1, 4'd2, 4'd0);
    Gra = 1'b1; Grb = 1'b1; Rin = 1'b1; bus_in = 32'h0000_0033;
    tick();
    idle();
    if (multi_sel_err !== 1'b1) begin errors++; $display("[TB] FAIL err_set: got %b want 1", multi_sel_err); end
    checks++;
    tick(); tick(); tick();
    if (multi_sel_err !== 1'b1) begin errors++; $display("[TB] FAIL err_sticky: got %b want 1", multi_sel_err); end
    checks++;
    Gra = 1'b1; Rout = 1'b1;
    ir = mk_ir(4'd3, 4'd0, 4'd0);
    #1;
    if (rdata !== 32'h33) begin errors++; $display("[TB] FAIL multi_R3: got %h want 33", rdata); end
    checks++;
    ir = mk_ir(4'd1, 4'd0, 4'd0);
    #1;
    if (rdata !== 32'h0) begin errors++; $display("[TB] FAIL multi_R1: got %h want 0", rdata); end
    checks++;
    if (wr_count !== 8'd5) begin errors++; $display("[TB] FAIL wr_count_5: got %0d want 5", wr_count); end
    checks++;
    idle();
    clear_n = 1'b0;
    tick();
    if (multi_sel_err !== 1'b0) begin errors++; $display("[TB] FAIL err_cleared: got %b want 0", multi_sel_err); end
    checks++;
    Gra = 1'b1; Rout = 1'b1;
    ir = mk_ir(4'd3, 4'd0, 4'd0);
    #1;
    if (rdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_R3: got %h want 0", rdata); end
    checks++;
    clear_n = 1'b1;
    idle();
  endtask

  task automatic test_reset_override();
    idle();
    ir = mk_ir(4'd7, 4'd0, 4'd0);
    Gra = 1'b1; Rin = 1'b1; bus_in = 32'h0000_0077;
    tick();
    clear_n = 1'b0;
    bus_in = 32'h0000_0088; HIin = 1'b1; LOin = 1'b1;
    tick();
    clear_n = 1'b1;
    idle();
    Gra = 1'b1; Rout = 1'b1;
    #1;
    if (rdata !== 32'h0) begin errors++; $display("[TB] FAIL override_R7: got %h want 0", rdata); end
    checks++;
    if (hi_q !== 32'h0) begin errors++; $display("[TB] FAIL override_hi: got %h want 0", hi_q); end
    checks++;
    if (wr_count !== 8'h0) begin errors++; $display("[TB] FAIL override_wr_count: got %0d want 0", wr_count); end
    checks++;
    idle();
  endtask

  task automatic test_saturation();
    idle();
    Gra = 1'b1; Rin = 1'b1;
    for (int n = 1; n <= 300; n++) begin
      ir = mk_ir(n[3:0], 4'd0, 4'd0);
      bus_in = n;
      tick();
      if (n == 254) begin
        if (wr_count !== 8'hFE) begin errors++; $display("[TB] FAIL wr_count_254: got %h want fe", wr_count); end
        checks++;
      end
      if (n == 255) begin
        if (wr_count !== 8'hFF) begin errors++; $display("[TB] FAIL wr_count_255: got %h want ff", wr_count); end
        checks++;
      end
    end
    if (wr_count !== 8'hFF) begin errors++; $display("[TB] FAIL wr_count_sat: got %h want ff", wr_count); end
    checks++;
    idle();
    HIin = 1'b1; bus_in = 32'd7;
    tick();
    idle();
    if (hi_q !== 32'd7) begin errors++; $display("[TB] FAIL hi_load: got %h want 7", hi_q); end
    checks++;
    if (wr_count !== 8'hFF) begin errors++; $display("[TB] FAIL hi_no_count: got %h want ff", wr_count); end
    checks++;
    LOin = 1'b1; Rin = 1'b1; Gra = 1'b1; bus_in = 32'h55;
    ir = mk_ir(4'd4, 4'd0, 4'd0);
    tick();
    Rin = 1'b0; LOin = 1'b0; Rout = 1'b1;
    #1;
    if (lo_q !== 32'h55) begin errors++; $display("[TB] FAIL lo_concurrent: got %h want 55", lo_q); end
    checks++;
    if (rdata !== 32'h55) begin errors++; $display("[TB] FAIL R4_concurrent: got %h want 55", rdata); end
    checks++;
    if (hi_q !== 32'd7) begin errors++; $display("[TB] FAIL hi_hold: got %h want 7", hi_q); end
    checks++;
    idle();
  endtask

  task automatic test_csign();
    ir = 32'h0004_0000;
    #1;
    if (csign !== 32'hFFFC_0000) begin errors++; $display("[TB] FAIL csign_neg: got %h want fffc0000", csign); end
    checks++;
    ir = 32'h0000_0005;
    #1;
    if (csign !== 32'h0000_0005) begin errors++; $display("[TB] FAIL csign_pos: got %h want 00000005", csign); end
    checks++;
    ir = 32'hFFF8_0001;
    #1;
    if (csign !== 32'h0000_0001) begin errors++; $display("[TB] FAIL csign_hibits: got %h want 00000001", csign); end
    checks++;
  endtask

  initial begin
    idle();
    clear_n = 1'b1;
    bus_in  = 32'h0;
    ir      = 32'h0;
    #2;
    test_reset();
    test_load_read();
    test_read_during_write();
    test_field_select();
    test_ba_read();
    test_multi_sel();
    test_reset_override();
    test_saturation();
    test_csign();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
